param_deser: RTL and testbench
==============================

PARAM_DESER -- requirements
Module: param_deser

Interface
REQ-001 The block SHALL have parameter F, default 3, meaning the MSB index of the output word.
REQ-002 The block SHALL have parameter K, default 0, meaning the LSB index of the output word; F >= K is required, and the word width is W = F-K+1.
REQ-003 The block SHALL have parameter P1, default 4, meaning clock cycles per serial bit; P1 >= 2 is required.
REQ-004 The block SHALL have parameter P2, default 1, meaning the number of stop bits checked; legal values are 1 and 2.
REQ-005 The block SHALL have port clk, input, width 1: the single clock, rising edge active.
REQ-006 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-007 The block SHALL have port d, input, width 1: serial line, synchronous to clk, idle high.
REQ-008 The block SHALL have port q, output, width [F:K]: received word.
REQ-009 The block SHALL have port q_valid, output, width 1: q holds an unconsumed word.
REQ-010 The block SHALL have port q_ready, input, width 1: the consumer accepts q when q_valid && q_ready.
REQ-011 The block SHALL have port overrun, output, width 1: sticky flag; a frame completed while the holding register was full.
REQ-012 The block SHALL have port frame_err, output, width 1: single-cycle pulse marking a stop bit sampled low.
REQ-013 The block SHALL have port parity_err, output, width 1: single-cycle pulse marking a parity mismatch.

Function
REQ-014 Frame format SHALL be: one start bit (0), then W data bits with bit K first and bit F last, then an optional parity bit (see Configuration), then P2 stop bits (1).
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE, d==0 SHALL move the FSM to START and load the bit counter with P1/2 (integer division).
REQ-017 At the START sample point, d==1 SHALL be treated as a false start: return to IDLE with no flags raised.
REQ-018 At the START sample point, d==0 SHALL move the FSM to DATA.
REQ-019 Each later sample point SHALL occur exactly P1 cycles after the previous one.
REQ-020 In DATA, each sample SHALL shift into the shift register at the top, so bit K ends in position K; after W samples the FSM SHALL move to PARITY (macro defined) or STOP (macro undefined).
REQ-021 In STOP, if any of the P2 stop samples is 0, the block SHALL pulse frame_err, discard the word, and return to IDLE.
REQ-022 If all P2 stop samples are 1, the word SHALL be committed on the cycle after the last stop sample, and the FSM SHALL return to IDLE on that same cycle.
REQ-023 Commit with q_valid==0, or with q_valid==1 && q_ready==1 on the same cycle, SHALL load q and set q_valid.
REQ-024 Commit with q_valid==1 && q_ready==0 SHALL keep the old q, drop the new word, and set overrun.
REQ-025 q_valid && q_ready without a commit SHALL clear q_valid on the next cycle; q SHALL hold its value.
REQ-026 overrun SHALL clear only on reset.
REQ-027 A new start bit SHALL be accepted on the cycle immediately after the FSM returns to IDLE.
REQ-028 The block SHALL support back-to-back frames with no gap beyond the stop bits.

Reset
REQ-029 rst_n low SHALL asynchronously force the FSM to IDLE and clear the counters and shift register.
REQ-030 rst_n low SHALL drive q=0, q_valid=0, overrun=0, frame_err=0, parity_err=0.
REQ-031 Reset mid-frame SHALL discard the partial word.
REQ-032 After rst_n rises, the first low d SHALL be treated as a start bit.

Configuration
REQ-033 With PARAM_DESER_PARITY_EN defined, one even-parity bit SHALL follow the data bits; a mismatch SHALL pulse parity_err at the parity sample point, discard the word, and return the FSM to IDLE.
REQ-034 With PARAM_DESER_PARITY_EN undefined, the PARITY state and parity logic SHALL be absent, parity_err SHALL be tied to 0, and the frame SHALL have no parity bit.

Verification
REQ-035 Scenario 1: F=3, K=0, P1=4, P2=1, no parity; send 0xA, q_ready=1 -> q=4'hA, q_valid high exactly one cycle, on the cycle after the stop sample.
REQ-036 Scenario 2: d low for 1 cycle in IDLE with P1=4 -> no q_valid, no flags, FSM back in IDLE.
REQ-037 Scenario 3: q_ready=0; send 0x5, then 0x3 -> q=4'h5, q_valid stays 1, overrun=1 after the second stop sample.
REQ-038 Scenario 4: send 0x6 with the stop bit driven 0 -> frame_err pulses one cycle, q_valid stays 0.
REQ-039 Scenario 5: with macro defined, send 0x7 with wrong parity -> parity_err pulse, no commit; then with correct parity -> q=4'h7.
REQ-040 Scenario 6: rst_n low during data bit 2 of 0xF, then send 0x9 -> all outputs 0 during reset; q=4'h9 afterwards.
REQ-041 Scenario 7: F=5, K=2, P2=2; send 0xB back-to-back twice with q_ready=1 -> two commits, q[5:2]=4'hB, no flags.

Source files
------------

// File: rtl/param_deser.sv
// Parameterised serial-to-parallel receiver: start bit, W data bits (LSB first), P2 stop bits.
// Optional even parity bit enabled by defining PARAM_DESER_PARITY_EN.
module param_deser #(
   parameter int F  = 3,
   parameter int K  = 0,
   parameter int P1 = 4,
   parameter int P2 = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         d,
   output logic [F:K]   q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         overrun,
   output logic         frame_err,
   output logic         parity_err
);

   localparam int W  = F - K + 1;
   localparam int CW = $clog2(P1 + 1);
   localparam int BW = $clog2(W + P2 + 1);

   localparam logic [CW-1:0] HALF      = CW'(P1 / 2);
   localparam logic [CW-1:0] FULL      = CW'(P1);
   localparam logic [BW-1:0] LAST_DATA = BW'(W - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(P2 - 1);

`ifdef PARAM_DESER_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [BW-1:0] bitcnt, bitcnt_nxt;
   logic [W-1:0]  sh, sh_nxt;
   logic          commit, commit_nxt;
   logic          ferr_nxt;
   logic          tick;

`ifdef PARAM_DESER_PARITY_EN
   logic          perr_nxt;
`endif

   // Sample point: the counter reaching 1 marks the cycle the line is read.
   assign tick = (cnt == CW'(1));

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      bitcnt_nxt = bitcnt;
      sh_nxt     = sh;
      commit_nxt = 1'b0;
      ferr_nxt   = 1'b0;
`ifdef PARAM_DESER_PARITY_EN
      perr_nxt   = 1'b0;
`endif
      if (state != IDLE && !tick)
         cnt_nxt = cnt - CW'(1);

      case (state)
         IDLE: begin
            if (!d) begin
               state_nxt = START;
               cnt_nxt   = HALF;
            end
         end
         START: begin
            if (tick) begin
               if (d) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt  = DATA;
                  cnt_nxt    = FULL;
                  bitcnt_nxt = '0;
               end
            end
         end
         DATA: begin
            if (tick) begin
               sh_nxt  = W'({d, sh} >> 1);
               cnt_nxt = FULL;
               if (bitcnt == LAST_DATA) begin
                  bitcnt_nxt = '0;
`ifdef PARAM_DESER_PARITY_EN
                  state_nxt  = PARITY;
`else
                  state_nxt  = STOP;
`endif
               end else begin
                  bitcnt_nxt = bitcnt + BW'(1);
               end
            end
         end
`ifdef PARAM_DESER_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (d != ^sh) begin
                  perr_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = STOP;
                  cnt_nxt   = FULL;
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (!d) begin
                  ferr_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else if (bitcnt == LAST_STOP) begin
                  commit_nxt = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  bitcnt_nxt = bitcnt + BW'(1);
                  cnt_nxt    = FULL;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bitcnt    <= '0;
         sh        <= '0;
         commit    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bitcnt    <= bitcnt_nxt;
         sh        <= sh_nxt;
         commit    <= commit_nxt;
         frame_err <= ferr_nxt;
      end
   end

`ifdef PARAM_DESER_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= perr_nxt;
   end
`else
   assign parity_err = 1'b0;
`endif

   // The shift register stays frozen in IDLE, so it still holds the word one cycle after the stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (commit) begin
         if (!q_valid || q_ready) begin
            q       <= sh;
            q_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (q_valid && q_ready) begin
         q_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_deser.sv
// Self-checking bench for param_deser: default instance plus an F=5,K=2,P2=2 instance.
// Expected timing comes from the frame rules: first sample P1/2 after start detection, then every P1.
module tb_param_deser;

   localparam int P1 = 4;
`ifdef PARAM_DESER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int HN = 8192;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic d0 = 1'b1, d1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
   logic [3:0] q0;
   logic [5:2] q1;
   logic v0, ov0, fe0, pe0, v1, ov1, fe1, pe1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   logic [3:0] q0_h[HN];
   logic [3:0] q1_h[HN];
   logic v0_h[HN], ov0_h[HN], fe0_h[HN], pe0_h[HN];
   logic v1_h[HN], ov1_h[HN], fe1_h[HN], pe1_h[HN];

   param_deser u0 (
      .clk(clk), .rst_n(rst_n), .d(d0), .q(q0), .q_valid(v0), .q_ready(rdy0),
      .overrun(ov0), .frame_err(fe0), .parity_err(pe0)
   );

   param_deser #(.F(5), .K(2), .P1(P1), .P2(2)) u1 (
      .clk(clk), .rst_n(rst_n), .d(d1), .q(q1), .q_valid(v1), .q_ready(rdy1),
      .overrun(ov1), .frame_err(fe1), .parity_err(pe1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // History indexed by edge number: entry n is the output state right after edge n.
   always @(negedge clk) begin
      if (cyc < HN) begin
         q0_h[cyc] <= q0;  v0_h[cyc] <= v0;  ov0_h[cyc] <= ov0;  fe0_h[cyc] <= fe0;  pe0_h[cyc] <= pe0;
         q1_h[cyc] <= q1;  v1_h[cyc] <= v1;  ov1_h[cyc] <= ov1;  fe1_h[cyc] <= fe1;  pe1_h[cyc] <= pe1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus and reference model ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int sel, input logic b);
      if (sel == 0) d0 = b; else d1 = b;
      idle(P1);
   endtask

   task automatic send_frame(input int sel, input int w, input int p2, input logic [7:0] data,
                             input bit bad_stop, input bit bad_par, output int t0);
      logic par;
      par = 1'b0;
      for (int i = 0; i < w; i++) par ^= data[i];
      t0 = cyc + 1;
      drive_bit(sel, 1'b0);
      for (int i = 0; i < w; i++) drive_bit(sel, data[i]);
`ifdef PARAM_DESER_PARITY_EN
      drive_bit(sel, par ^ bad_par);
`else
      if (bad_par || par) begin end
`endif
      for (int i = 0; i < p2; i++) drive_bit(sel, !(bad_stop && i == p2 - 1));
      if (sel == 0) d0 = 1'b1; else d1 = 1'b1;
   endtask

   function automatic int t_stop(input int t0, input int w, input int p2);
      return t0 + P1 / 2 + (w + PAR + p2) * P1;
   endfunction

   function automatic int t_par(input int t0, input int w);
      return t0 + P1 / 2 + (w + 1) * P1;
   endfunction

   function automatic int rises(input int sel, input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++)
         if (i > 0 && i < HN) begin
            if (sel == 0 && v0_h[i] && !v0_h[i-1]) n++;
            if (sel == 1 && v1_h[i] && !v1_h[i-1]) n++;
         end
      return n;
   endfunction

   // which: 0 fe0, 1 pe0, 2 ov0, 3 fe1, 4 pe1, 5 ov1
   function automatic int highs(input int which, input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++)
         if (i >= 0 && i < HN) begin
            case (which)
               0: n += int'(fe0_h[i]);
               1: n += int'(pe0_h[i]);
               2: n += int'(ov0_h[i]);
               3: n += int'(fe1_h[i]);
               4: n += int'(pe1_h[i]);
               default: n += int'(ov1_h[i]);
            endcase
         end
      return n;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({q0, v0, ov0, fe0, pe0} !== 8'h00) begin errors++; $display("FAIL reset_dut0 got %h exp 00", {q0, v0, ov0, fe0, pe0}); end
      checks++; if ({q1, v1, ov1, fe1, pe1} !== 8'h00) begin errors++; $display("FAIL reset_dut1 got %h exp 00", {q1, v1, ov1, fe1, pe1}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3);
      checks++; if ({q0, v0, ov0, fe0, pe0} !== 8'h00) begin errors++; $display("FAIL post_reset_dut0 got %h exp 00", {q0, v0, ov0, fe0, pe0}); end
   endtask

   task automatic test_single;
      int t0, tc;
      rdy0 = 1'b1;
      send_frame(0, 4, 1, 8'hA, 1'b0, 1'b0, t0);
      idle(2);
      tc = t_stop(t0, 4, 1) + 1;
      checks++; if (v0_h[tc-1] !== 1'b0) begin errors++; $display("FAIL s1_valid_early got %b exp 0", v0_h[tc-1]); end
      checks++; if (v0_h[tc] !== 1'b1)   begin errors++; $display("FAIL s1_valid got %b exp 1", v0_h[tc]); end
      checks++; if (q0_h[tc] !== 4'hA)   begin errors++; $display("FAIL s1_q got %h exp a", q0_h[tc]); end
      checks++; if (v0_h[tc+1] !== 1'b0) begin errors++; $display("FAIL s1_valid_width got %b exp 0", v0_h[tc+1]); end
      checks++; if (highs(0, t0, tc + 1) + highs(1, t0, tc + 1) + highs(2, t0, tc + 1) !== 0)
         begin errors++; $display("FAIL s1_flags got %0d exp 0", highs(0, t0, tc + 1) + highs(1, t0, tc + 1) + highs(2, t0, tc + 1)); end
   endtask

   task automatic test_false_start;
      int a, t0, tc;
      a = cyc;
      d0 = 1'b0;
      idle(1);
      d0 = 1'b1;
      idle(3 * P1);
      checks++; if (rises(0, a, cyc) !== 0) begin errors++; $display("FAIL s2_no_valid got %0d exp 0", rises(0, a, cyc)); end
      checks++; if (highs(0, a, cyc) + highs(1, a, cyc) !== 0) begin errors++; $display("FAIL s2_no_flags got %0d exp 0", highs(0, a, cyc) + highs(1, a, cyc)); end
      send_frame(0, 4, 1, 8'hC, 1'b0, 1'b0, t0);
      idle(2);
      tc = t_stop(t0, 4, 1) + 1;
      checks++; if ({v0_h[tc], q0_h[tc]} !== 5'h1C) begin errors++; $display("FAIL s2_idle_recovery got %h exp 1c", {v0_h[tc], q0_h[tc]}); end
   endtask

   task automatic test_overrun;
      int t0a, t0b, tca, tcb;
      rdy0 = 1'b0;
      send_frame(0, 4, 1, 8'h5, 1'b0, 1'b0, t0a);
      send_frame(0, 4, 1, 8'h3, 1'b0, 1'b0, t0b);
      idle(2);
      tca = t_stop(t0a, 4, 1) + 1;
      tcb = t_stop(t0b, 4, 1) + 1;
      checks++; if ({v0_h[tca], q0_h[tca]} !== 5'h15) begin errors++; $display("FAIL s3_first got %h exp 15", {v0_h[tca], q0_h[tca]}); end
      checks++; if (ov0_h[tcb-1] !== 1'b0) begin errors++; $display("FAIL s3_ovr_early got %b exp 0", ov0_h[tcb-1]); end
      checks++; if (ov0_h[tcb] !== 1'b1)   begin errors++; $display("FAIL s3_ovr got %b exp 1", ov0_h[tcb]); end
      checks++; if ({v0_h[tcb], q0_h[tcb]} !== 5'h15) begin errors++; $display("FAIL s3_hold got %h exp 15", {v0_h[tcb], q0_h[tcb]}); end
      rdy0 = 1'b1;
      idle(1);
      rdy0 = 1'b0;
      idle(2);
      checks++; if ({v0, q0, ov0} !== 6'h0B) begin errors++; $display("FAIL s3_drain got %h exp 0b", {v0, q0, ov0}); end
   endtask

   task automatic test_reset_mid;
      int t0, tstart, t0b, tc;
      tstart = cyc + 1;
      fork
         send_frame(0, 4, 1, 8'hF, 1'b0, 1'b0, t0);
         begin
            idle(3 * P1 + 1);
            rst_n = 1'b0;
            @(negedge clk);
            checks++; if ({q0, v0, ov0, fe0, pe0} !== 8'h00) begin errors++; $display("FAIL s6_in_reset got %h exp 00", {q0, v0, ov0, fe0, pe0}); end
            idle(P1);
            rst_n = 1'b1;
         end
      join
      idle(2 * P1);
      checks++; if (rises(0, tstart, cyc) !== 0) begin errors++; $display("FAIL s6_partial_dropped got %0d exp 0", rises(0, tstart, cyc)); end
      rdy0 = 1'b1;
      send_frame(0, 4, 1, 8'h9, 1'b0, 1'b0, t0b);
      idle(2);
      tc = t_stop(t0b, 4, 1) + 1;
      checks++; if ({v0_h[tc], q0_h[tc]} !== 5'h19) begin errors++; $display("FAIL s6_after got %h exp 19", {v0_h[tc], q0_h[tc]}); end
   endtask

   task automatic test_frame_err;
      int t0, ts;
      rdy0 = 1'b1;
      send_frame(0, 4, 1, 8'h6, 1'b1, 1'b0, t0);
      idle(P1 + 1);
      ts = t_stop(t0, 4, 1);
      checks++; if ({fe0_h[ts-1], fe0_h[ts], fe0_h[ts+1]} !== 3'b010)
         begin errors++; $display("FAIL s4_ferr_pulse got %b exp 010", {fe0_h[ts-1], fe0_h[ts], fe0_h[ts+1]}); end
      checks++; if (rises(0, t0, cyc) !== 0) begin errors++; $display("FAIL s4_no_commit got %0d exp 0", rises(0, t0, cyc)); end
   endtask

`ifdef PARAM_DESER_PARITY_EN
   task automatic test_parity;
      int t0, tp, tc;
      rdy0 = 1'b1;
      send_frame(0, 4, 1, 8'h7, 1'b0, 1'b1, t0);
      idle(P1 + 1);
      tp = t_par(t0, 4);
      checks++; if ({pe0_h[tp-1], pe0_h[tp], pe0_h[tp+1]} !== 3'b010)
         begin errors++; $display("FAIL s5_perr_pulse got %b exp 010", {pe0_h[tp-1], pe0_h[tp], pe0_h[tp+1]}); end
      checks++; if (rises(0, t0, cyc) !== 0) begin errors++; $display("FAIL s5_no_commit got %0d exp 0", rises(0, t0, cyc)); end
      send_frame(0, 4, 1, 8'h7, 1'b0, 1'b0, t0);
      idle(2);
      tc = t_stop(t0, 4, 1) + 1;
      checks++; if ({v0_h[tc], q0_h[tc]} !== 5'h17) begin errors++; $display("FAIL s5_good got %h exp 17", {v0_h[tc], q0_h[tc]}); end
   endtask
`endif

   task automatic test_back_to_back;
      int t0a, t0b, tca, tcb;
      rdy1 = 1'b1;
      send_frame(1, 4, 2, 8'hB, 1'b0, 1'b0, t0a);
      send_frame(1, 4, 2, 8'hB, 1'b0, 1'b0, t0b);
      idle(3);
      tca = t_stop(t0a, 4, 2) + 1;
      tcb = t_stop(t0b, 4, 2) + 1;
      checks++; if ({v1_h[tca], q1_h[tca]} !== 5'h1B) begin errors++; $display("FAIL s7_first got %h exp 1b", {v1_h[tca], q1_h[tca]}); end
      checks++; if ({v1_h[tcb], q1_h[tcb]} !== 5'h1B) begin errors++; $display("FAIL s7_second got %h exp 1b", {v1_h[tcb], q1_h[tcb]}); end
      checks++; if (rises(1, t0a, cyc) !== 2) begin errors++; $display("FAIL s7_commits got %0d exp 2", rises(1, t0a, cyc)); end
      checks++; if (highs(3, t0a, cyc) + highs(4, t0a, cyc) + highs(5, t0a, cyc) !== 0)
         begin errors++; $display("FAIL s7_flags got %0d exp 0", highs(3, t0a, cyc) + highs(4, t0a, cyc) + highs(5, t0a, cyc)); end
   endtask

   task automatic test_random;
      localparam int N = 12;
      int t0s[N];
      logic [3:0] ds[N];
      int kinds[N];
      int n_good, n_fe, n_pe, a, r, t;
      n_good = 0; n_fe = 0; n_pe = 0;
      rdy0 = 1'b1;
      a = cyc;
      for (int i = 0; i < N; i++) begin
         ds[i] = 4'($urandom_range(0, 15));
         r = int'($urandom_range(0, 3));
         kinds[i] = (r == 0) ? 1 : ((PAR == 1 && r == 1) ? 2 : 0);
         send_frame(0, 4, 1, {4'h0, ds[i]}, kinds[i] == 1, kinds[i] == 2, t);
         t0s[i] = t;
         if (kinds[i] != 0) idle(P1 + 1);
         else idle(int'($urandom_range(0, 2)));
      end
      idle(2 * P1);
      for (int i = 0; i < N; i++) begin
         if (kinds[i] == 0) begin
            n_good++;
            t = t_stop(t0s[i], 4, 1) + 1;
            checks++; if ({v0_h[t], q0_h[t]} !== {1'b1, ds[i]}) begin errors++; $display("FAIL rnd_word[%0d] got %h exp %h", i, {v0_h[t], q0_h[t]}, {1'b1, ds[i]}); end
         end else if (kinds[i] == 1) begin
            n_fe++;
            t = t_stop(t0s[i], 4, 1);
            checks++; if (fe0_h[t] !== 1'b1) begin errors++; $display("FAIL rnd_ferr[%0d] got %b exp 1", i, fe0_h[t]); end
         end else begin
            n_pe++;
            t = t_par(t0s[i], 4);
            checks++; if (pe0_h[t] !== 1'b1) begin errors++; $display("FAIL rnd_perr[%0d] got %b exp 1", i, pe0_h[t]); end
         end
      end
      checks++; if (rises(0, a, cyc) !== n_good) begin errors++; $display("FAIL rnd_commit_count got %0d exp %0d", rises(0, a, cyc), n_good); end
      checks++; if (highs(0, a, cyc) !== n_fe)   begin errors++; $display("FAIL rnd_ferr_count got %0d exp %0d", highs(0, a, cyc), n_fe); end
      checks++; if (highs(1, a, cyc) !== n_pe)   begin errors++; $display("FAIL rnd_perr_count got %0d exp %0d", highs(1, a, cyc), n_pe); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_false_start;
      test_overrun;
      test_reset_mid;
      test_frame_err;
`ifdef PARAM_DESER_PARITY_EN
      test_parity;
`endif
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
